// File: rtl/frame_receiver.sv
// frame_receiver: receiver for 10-bit serial frames (start 0, 8 data bits LSB first, stop 1),
// with the line idling high. Each bit is sampled mid-period against a fixed CLKS_PER_BIT count.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (even, 4..1024)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_in       serial line, idle high
//   data_out    last correctly received byte; holds until the next good frame
//   frame_out   raw last completed frame {stop, data[7:0], start}; updated on good and bad frames
//   data_valid  one-cycle pulse when data_out updates
//   frame_err   one-cycle pulse when the sampled stop bit is 0
//   busy        high whenever the receiver is not idle
//
// Configuration macro:
//   FRAME_RX_SYNC_EN  when defined, rx_in passes through a 2-flop synchronizer (reset to 1)
//                     before use, adding two cycles of latency. When undefined, rx_in must
//                     already be synchronous to clk.

module frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic [9:0] frame_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  // Terminal counts: half a bit to reach the middle of the start bit, a full bit afterwards.
  localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  // --------------------------------------------------------------------------
  // Line conditioning
  // --------------------------------------------------------------------------
  logic rx_s;

`ifdef FRAME_RX_SYNC_EN
  // Reset to the idle level so leaving reset never looks like a start edge.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic [9:0]      frame_q, frame_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end

      StStart: begin
        if (cnt_q == HalfMax) begin
          cnt_d = '0;
          // A line that is high again mid start bit was only a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == FullMax) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == FullMax) begin
          cnt_d   = '0;
          frame_d = {rx_s, shift_q, 1'b0};
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line (break) must not be taken as the next start bit.
      StWaitIdle: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Registered from the next state so busy drops in the same cycle as the pulse.
    busy_d = (state_d != StIdle);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_out   = data_q;
  assign frame_out  = frame_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

  pulses_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(data_valid && frame_err));

endmodule
